cordic_sign_seq: RTL

CORDIC_SIGN_SEQ -- requirements
Module: cordic_sign_seq

---
 rtl/cordic_sign_seq_pkg.sv | 18 +
 rtl/cordic_dir_decode.sv | 31 +++
 rtl/cordic_sign_seq.sv | 124 ++++++++++++
 3 files changed

// File: rtl/cordic_sign_seq_pkg.sv
// Shared definitions for the CORDIC sign/shift sequencer: state encoding,
// mode/coordinate constants and the first hyperbolic repeat index.
package cordic_sign_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  localparam logic MODE_VECTORING   = 1'b0;
  localparam logic MODE_ROTATION    = 1'b1;
  localparam logic COORD_HYPERBOLIC = 1'b0;
  localparam logic COORD_CIRCULAR   = 1'b1;

  localparam int FIRST_REP = 4;

endpackage

// File: rtl/cordic_dir_decode.sv
// Combinational rotation-direction decode: turns the current Y/Z sign bits into
// add/sub selects for the X, Y and Z updates, forced low when no step is shown.
module cordic_dir_decode
  import cordic_sign_seq_pkg::*;
(
  input  logic mode,
  input  logic coord,
  input  logic step_valid,
  input  logic sign_y_in,
  input  logic sign_z_in,
  output logic op_x,
  output logic op_y,
  output logic op_z
);

  logic d_pos;

  always_comb begin
    d_pos = (mode == MODE_ROTATION) ? ~sign_z_in : sign_y_in;
    op_x  = 1'b0;
    op_y  = 1'b0;
    op_z  = 1'b0;
    if (step_valid) begin
      // Z always moves against d; X differs between hyperbolic and circular.
      op_z = d_pos;
      op_y = ~d_pos;
      op_x = (coord == COORD_CIRCULAR) ? d_pos : ~d_pos;
    end
  end

endmodule

// File: rtl/cordic_sign_seq.sv
// CORDIC iteration sequencer: steps the shift index per datapath advance,
// inserts the hyperbolic repeat iterations (4, 13, 40, ...) and flags completion.
module cordic_sign_seq
  import cordic_sign_seq_pkg::*;
#(
  parameter int ITER  = 16,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic             coord,
  input  logic             adv,
  input  logic             sign_y_in,
  input  logic             sign_z_in,
  output logic             op_x,
  output logic             op_y,
  output logic             op_z,
  output logic [IDX_W-1:0] shift,
  output logic             step_valid,
  output logic             busy,
  output logic             done
);

  // 3*rep+1 of any rep reachable from a valid shift index fits in two extra bits.
  localparam int REP_W = IDX_W + 2;

  state_t           state, state_next;
  logic [IDX_W-1:0] shift_next;
  logic [REP_W-1:0] rep, rep_next;
  logic             rep_flag, rep_flag_next;
  logic             mode_lat, mode_next;
  logic             coord_lat, coord_next;
  logic             repeat_due;
  logic             last_step;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      shift      <= '0;
      rep        <= REP_W'(FIRST_REP);
      rep_flag   <= 1'b0;
      mode_lat   <= 1'b0;
      coord_lat  <= 1'b0;
      step_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      shift      <= shift_next;
      rep        <= rep_next;
      rep_flag   <= rep_flag_next;
      mode_lat   <= mode_next;
      coord_lat  <= coord_next;
      step_valid <= (state_next == ST_RUN);
      busy       <= (state_next != ST_IDLE);
      done       <= (state_next == ST_FIN);
    end
  end

  always_comb begin
    state_next    = state;
    shift_next    = shift;
    rep_next      = rep;
    rep_flag_next = rep_flag;
    mode_next     = mode_lat;
    coord_next    = coord_lat;

    repeat_due = (coord_lat == COORD_HYPERBOLIC) && !rep_flag &&
                 ({2'b00, shift} == rep);
    if (coord_lat == COORD_HYPERBOLIC)
      last_step = (shift == IDX_W'(ITER)) && !repeat_due;
    else
      last_step = (shift == IDX_W'(ITER - 1));

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          mode_next     = mode;
          coord_next    = coord;
          shift_next    = (coord == COORD_HYPERBOLIC) ? IDX_W'(1) : '0;
          rep_next      = REP_W'(FIRST_REP);
          rep_flag_next = 1'b0;
          state_next    = ST_RUN;
        end
      end
      ST_RUN: begin
        if (adv) begin
          if (last_step) begin
            shift_next = '0;
            state_next = ST_FIN;
          end else if (repeat_due) begin
            rep_flag_next = 1'b1;
          end else if (rep_flag) begin
            shift_next    = shift + IDX_W'(1);
            rep_flag_next = 1'b0;
            rep_next      = (rep << 1) + rep + REP_W'(1);
          end else begin
            shift_next = shift + IDX_W'(1);
          end
        end
      end
      ST_FIN: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  cordic_dir_decode u_dir_decode (
    .mode       (mode_lat),
    .coord      (coord_lat),
    .step_valid (step_valid),
    .sign_y_in  (sign_y_in),
    .sign_z_in  (sign_z_in),
    .op_x       (op_x),
    .op_y       (op_y),
    .op_z       (op_z)
  );

endmodule
